// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter that time-shares one external 16-bit adder.
// The winner's operands are registered onto the adder and the sum is captured after SETTLE_CYCLES cycles.
module adder_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic        cin0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic        cin1,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_ovf,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        result_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  // favour_q names the requester that wins a tie; it points away from the one served last.
  logic        favour_q, favour_d;
  logic        sel_q, sel_d;
  logic        gnt_q, gnt_d;
  logic        done_q, done_d;
  logic [15:0] add_a_q, add_a_d;
  logic [15:0] add_b_q, add_b_d;
  logic        add_cin_q, add_cin_d;
  logic [15:0] result_q, result_d;
  logic        result_ovf_q, result_ovf_d;
  logic        winner;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    favour_d     = favour_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    done_d       = 1'b0;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_cin_d    = add_cin_q;
    result_d     = result_q;
    result_ovf_d = result_ovf_q;
    winner       = (req0 && req1) ? favour_q : req1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d     = winner;
          add_a_d   = winner ? a1 : a0;
          add_b_d   = winner ? b1 : b0;
          add_cin_d = winner ? cin1 : cin0;
          gnt_d     = 1'b1;
          cnt_d     = 4'd0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          result_d     = add_sum;
          result_ovf_d = add_ovf;
          favour_d     = ~sel_q;
          done_d       = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        gnt_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      favour_q     <= 1'b0;
      sel_q        <= 1'b0;
      gnt_q        <= 1'b0;
      done_q       <= 1'b0;
      add_a_q      <= 16'd0;
      add_b_q      <= 16'd0;
      add_cin_q    <= 1'b0;
      result_q     <= 16'd0;
      result_ovf_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      favour_q     <= favour_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_cin_q    <= add_cin_d;
      result_q     <= result_d;
      result_ovf_q <= result_ovf_d;
    end
  end

  // A single grant/done flag steered by sel_q makes the pairs mutually exclusive by construction.
  assign gnt0       = gnt_q & ~sel_q;
  assign gnt1       = gnt_q & sel_q;
  assign done0      = done_q & ~sel_q;
  assign done1      = done_q & sel_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_cin    = add_cin_q;
  assign result     = result_q;
  assign result_ovf = result_ovf_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: vector table, corner sequences and a randomized run against a transaction model.
// Three instances (SETTLE_CYCLES 2, 1, 15) share inputs; each has its own behavioural adder.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req0, req1, cin0, cin1;
  logic [15:0] a0, b0, a1, b1;

  always #5 clk = ~clk;

  // main instance, SETTLE_CYCLES = 2
  logic [15:0] add_a_m, add_b_m, add_sum_m, result_m;
  logic        add_cin_m, add_ovf_m, gnt0_m, gnt1_m, done0_m, done1_m, result_ovf_m, busy_m;
  // sweep instances
  logic [15:0] add_a_s1, add_b_s1, add_sum_s1, result_s1;
  logic        add_cin_s1, add_ovf_s1, gnt0_s1, gnt1_s1, done0_s1, done1_s1, result_ovf_s1, busy_s1;
  logic [15:0] add_a_s15, add_b_s15, add_sum_s15, result_s15;
  logic        add_cin_s15, add_ovf_s15, gnt0_s15, gnt1_s15, done0_s15, done1_s15, result_ovf_s15, busy_s15;

  assign {add_ovf_m, add_sum_m}     = {1'b0, add_a_m} + {1'b0, add_b_m} + 17'(add_cin_m);
  assign {add_ovf_s1, add_sum_s1}   = {1'b0, add_a_s1} + {1'b0, add_b_s1} + 17'(add_cin_s1);
  assign {add_ovf_s15, add_sum_s15} = {1'b0, add_a_s15} + {1'b0, add_b_s15} + 17'(add_cin_s15);

  adder_arbiter #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
    .add_a(add_a_m), .add_b(add_b_m), .add_cin(add_cin_m),
    .add_sum(add_sum_m), .add_ovf(add_ovf_m),
    .gnt0(gnt0_m), .gnt1(gnt1_m), .done0(done0_m), .done1(done1_m),
    .result(result_m), .result_ovf(result_ovf_m), .busy(busy_m)
  );

  adder_arbiter #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
    .add_a(add_a_s1), .add_b(add_b_s1), .add_cin(add_cin_s1),
    .add_sum(add_sum_s1), .add_ovf(add_ovf_s1),
    .gnt0(gnt0_s1), .gnt1(gnt1_s1), .done0(done0_s1), .done1(done1_s1),
    .result(result_s1), .result_ovf(result_ovf_s1), .busy(busy_s1)
  );

  adder_arbiter #(.SETTLE_CYCLES(15)) u_dut_s15 (
    .clk(clk), .n_rst(n_rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
    .add_a(add_a_s15), .add_b(add_b_s15), .add_cin(add_cin_s15),
    .add_sum(add_sum_s15), .add_ovf(add_ovf_s15),
    .gnt0(gnt0_s15), .gnt1(gnt1_s15), .done0(done0_s15), .done1(done1_s15),
    .result(result_s15), .result_ovf(result_ovf_s15), .busy(busy_s15)
  );

  typedef struct {
    logic        r0, r1;
    logic [15:0] a0, b0;
    logic        cin0;
    logic [15:0] a1, b1;
    logic        cin1;
    logic        exp_w;
    logic [15:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  // One complete transaction on the main instance; expectations come from the caller.
  task automatic run_txn(input logic r0, input logic r1,
                         input logic [15:0] a0v, input logic [15:0] b0v, input logic cin0v,
                         input logic [15:0] a1v, input logic [15:0] b1v, input logic cin1v,
                         input logic exp_w, input logic [15:0] exp_res, input logic exp_ovf,
                         input bit scramble, input string tag);
    int k;
    int lat;
    req0 = r0; req1 = r1;
    a0 = a0v; b0 = b0v; cin0 = cin0v;
    a1 = a1v; b1 = b1v; cin1 = cin1v;
    k = 0;
    tick();
    while (!(gnt0_m || gnt1_m) && k < 8) begin
      tick();
      k++;
    end
    check({tag, ".grant_seen"}, 32'(gnt0_m | gnt1_m), 32'd1);
    check({tag, ".grant_latency"}, 32'(k), 32'd0);
    check({tag, ".gnt1"}, 32'(gnt1_m), 32'(exp_w));
    check({tag, ".gnt0"}, 32'(gnt0_m), 32'(!exp_w));
    check({tag, ".busy"}, 32'(busy_m), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    if (scramble) begin
      a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
    end
    lat = 0;
    while (!(done0_m || done1_m) && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".done_latency"}, 32'(lat), 32'd2);
    check({tag, ".done1"}, 32'(done1_m), 32'(exp_w));
    check({tag, ".done0"}, 32'(done0_m), 32'(!exp_w));
    check({tag, ".gnt_in_done"}, 32'(exp_w ? gnt1_m : gnt0_m), 32'd1);
    check({tag, ".result"}, 32'(result_m), 32'(exp_res));
    check({tag, ".result_ovf"}, 32'(result_ovf_m), 32'(exp_ovf));
    tick();
    check({tag, ".gnt_released"}, 32'(gnt0_m | gnt1_m), 32'd0);
    check({tag, ".done_single"}, 32'(done0_m | done1_m), 32'd0);
    check({tag, ".idle"}, 32'(busy_m), 32'd0);
    check({tag, ".result_held"}, 32'(result_m), 32'(exp_res));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[6];
    logic  favour;
    logic  prev_gnt;
    logic  winners[$];
    logic  w;
    logic  [16:0] full;
    int    first1, first15;

    vecs[0] = '{1'b1, 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h2345, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0, 16'h1111, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 16'h9999, 16'h9999, 1'b1, 16'h0100, 16'h0200, 1'b0, 1'b1, 16'h0300, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 1'b1, 16'h8000, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 16'h0001, 16'h0002, 1'b1, 16'h4444, 16'h4444, 1'b0, 1'b0, 16'h0004, 1'b0};

    req0 = 1'b0; req1 = 1'b0; cin0 = 1'b0; cin1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    n_rst = 1'b0;
    #3;
    check("reset.busy", 32'(busy_m), 32'd0);
    check("reset.gnt", 32'({gnt0_m, gnt1_m}), 32'd0);
    check("reset.done", 32'({done0_m, done1_m}), 32'd0);
    check("reset.result", 32'({result_ovf_m, result_m}), 32'd0);
    check("reset.add", 32'({add_cin_m, add_a_m} ^ {1'b0, add_b_m}), 32'd0);
    tick();
    n_rst = 1'b1;

    // Vector table: the first entries cover the single request, tie-break and wrap cases.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].b0, vecs[i].cin0,
              vecs[i].a1, vecs[i].b1, vecs[i].cin1,
              vecs[i].exp_w, vecs[i].exp_res, vecs[i].exp_ovf, 1'b0, $sformatf("vec%0d", i));
    end

    // Operands change one cycle after the grant; the latched values must still be used.
    run_txn(1'b1, 1'b0, 16'h0005, 16'h0003, 1'b0, 16'h0000, 16'h0000, 1'b0,
            1'b0, 16'h0008, 1'b0, 1'b0, "opchg_pre");
    req0 = 1'b1; a0 = 16'h0005; b0 = 16'h0003; cin0 = 1'b0;
    tick();
    check("opchg.gnt0", 32'(gnt0_m), 32'd1);
    req0 = 1'b0;
    a0 = 16'hAAAA;
    tick();
    check("opchg.add_a", 32'(add_a_m), 32'h0005);
    tick();
    check("opchg.done0", 32'(done0_m), 32'd1);
    check("opchg.result", 32'(result_m), 32'h0008);
    tick();

    // Requester 0 was served last, so requester 1 is favoured until reset clears it.
    req0 = 1'b1; a0 = 16'h0101; b0 = 16'h0101; cin0 = 1'b0;
    tick();
    check("rst_mid.gnt0", 32'(gnt0_m), 32'd1);
    req0 = 1'b0;
    tick();
    #1 n_rst = 1'b0;
    #1;
    check("rst_mid.busy", 32'(busy_m), 32'd0);
    check("rst_mid.gnt", 32'({gnt0_m, gnt1_m}), 32'd0);
    check("rst_mid.outputs", 32'({result_ovf_m, result_m} | {add_cin_m, add_a_m} | {1'b0, add_b_m}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid.no_done", 32'({done0_m, done1_m}), 32'd0);
    end
    n_rst = 1'b1;
    run_txn(1'b1, 1'b1, 16'h0010, 16'h0020, 1'b1, 16'h0300, 16'h0400, 1'b0,
            1'b0, 16'h0031, 1'b0, 1'b0, "rst_after");

    // Both requests held continuously after reset: grants alternate 0,1,0 and never overlap.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    prev_gnt = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("hold.no_overlap", 32'({gnt0_m & gnt1_m, done0_m & done1_m}), 32'd0);
      if ((gnt0_m || gnt1_m) && !prev_gnt) winners.push_back(gnt1_m);
      prev_gnt = gnt0_m | gnt1_m;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("hold.grant_count", 32'(winners.size() >= 3), 32'd1);
    if (winners.size() >= 3) begin
      check("hold.first", 32'(winners[0]), 32'd0);
      check("hold.second", 32'(winners[1]), 32'd1);
      check("hold.third", 32'(winners[2]), 32'd0);
    end
    for (int i = 0; i < 5; i++) tick();

    // Randomized transactions against a transaction-level model of arbitration and addition.
    do_reset();
    favour = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] r;
      logic [15:0] ra0, rb0, ra1, rb1;
      logic rc0, rc1;
      r = 2'($urandom_range(1, 3));
      ra0 = 16'($urandom); rb0 = 16'($urandom); rc0 = 1'($urandom);
      ra1 = 16'($urandom); rb1 = 16'($urandom); rc1 = 1'($urandom);
      w = (r == 2'b11) ? favour : r[1];
      full = w ? (17'(ra1) + 17'(rb1) + 17'(rc1)) : (17'(ra0) + 17'(rb0) + 17'(rc0));
      run_txn(r[0], r[1], ra0, rb0, rc0, ra1, rb1, rc1, w, full[15:0], full[16], 1'b1,
              $sformatf("rand%0d", i));
      favour = !w;
    end

    // Latency sweep on the SETTLE_CYCLES = 1 and 15 instances.
    do_reset();
    req0 = 1'b1; a0 = 16'h0010; b0 = 16'h0020; cin0 = 1'b0;
    tick();
    check("sweep.gnt_s1", 32'(gnt0_s1), 32'd1);
    check("sweep.gnt_s15", 32'(gnt0_s15), 32'd1);
    req0 = 1'b0;
    first1 = -1; first15 = -1;
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (done0_s1 && first1 < 0) first1 = t;
      if (done0_s15 && first15 < 0) first15 = t;
      if (t <= 15) check($sformatf("sweep.busy_s15_t%0d", t), 32'(busy_s15), 32'd1);
      if (t == 1) check("sweep.busy_s1_done", 32'(busy_s1), 32'd1);
      if (t == 2) check("sweep.busy_s1_idle", 32'(busy_s1), 32'd0);
      if (t == 16) check("sweep.busy_s15_idle", 32'(busy_s15), 32'd0);
    end
    check("sweep.latency_s1", 32'(first1), 32'd1);
    check("sweep.latency_s15", 32'(first15), 32'd15);
    check("sweep.result_s15", 32'(result_s15), 32'h0030);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
